// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard controller.
package hazard_pkg;

  // E-stage operand mux selects
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB   = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_MEM  = 2'b10;  // M-stage ALU result
  localparam logic [1:0] FWD_LUI  = 2'b11;  // M-stage LUI immediate

  // Multi-cycle execute timer states
  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/mc_stall_timer.sv
// Multi-cycle execute timer: holds the pipeline while an iterative
// mul/div occupies E for mcLatE cycles. The first cycle is spent in IDLE,
// so BUSY only has to count the remaining mcLatE-1 cycles.
module mc_stall_timer
  import hazard_pkg::*;
#(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mcStartE,
  input  logic [LAT_W-1:0] mcLatE,
  output logic             mcStall,
  output logic             mcBusy
);

  mc_state_e        state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  // Next-state / counter logic; stall is asserted on every cycle but the last
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcStall = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (mcStartE && (mcLatE >= LAT_W'(2))) begin
          mcStall = 1'b1;
          state_d = MC_BUSY;
          cnt_d   = mcLatE - LAT_W'(2);
        end
      end
      MC_BUSY: begin
        // mcStartE is the same instruction still sitting in E; ignore it
        if (cnt_q != '0) begin
          mcStall = 1'b1;
          cnt_d   = cnt_q - LAT_W'(1);
        end else begin
          state_d = MC_IDLE;
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mcBusy = (state_q == MC_BUSY);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage pipeline: E-stage forwarding with LUI
// bypass, load-use stall, branch flush, multi-cycle execute stall with an
// M-stage bubble, and a saturating stall-cycle counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 4,
  parameter int PERF_W  = 16,
  parameter int PCSRC_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_AW-1:0]  Rs1D,
  input  logic [REG_AW-1:0]  Rs2D,
  input  logic [REG_AW-1:0]  Rs1E,
  input  logic [REG_AW-1:0]  Rs2E,
  input  logic [REG_AW-1:0]  RdE,
  input  logic [REG_AW-1:0]  RdM,
  input  logic [REG_AW-1:0]  RdW,
  input  logic               regWriteM,
  input  logic               regWriteW,
  input  logic               luiM,
  input  logic               resultSrcE0,
  input  logic [PCSRC_W-1:0] PCSrcE,
  input  logic               mcStartE,
  input  logic [LAT_W-1:0]   mcLatE,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               flushD,
  output logic               flushE,
  output logic               flushM,
  output logic [1:0]         forwardAE,
  output logic [1:0]         forwardBE,
  output logic               mcBusy,
  output logic [PERF_W-1:0]  stallCount
);

  logic              mc_stall;
  logic              lw_stall;
  logic [PERF_W-1:0] stall_count_q, stall_count_d;

  mc_stall_timer #(.LAT_W(LAT_W)) u_mc_timer (
    .clk      (clk),
    .reset    (reset),
    .mcStartE (mcStartE),
    .mcLatE   (mcLatE),
    .mcStall  (mc_stall),
    .mcBusy   (mcBusy)
  );

  // x0 never forwards; the youngest producer (M) wins over W
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (rs == '0)                    return FWD_NONE;
    else if (rs == RdM && regWriteM) return luiM ? FWD_LUI : FWD_MEM;
    else if (rs == RdW && regWriteW) return FWD_WB;
    else                             return FWD_NONE;
  endfunction

  // Operand forwarding selects, forced to register-file path during reset
  always_comb begin
    forwardAE = FWD_NONE;
    forwardBE = FWD_NONE;
    if (!reset) begin
      forwardAE = fwd_sel(Rs1E);
      forwardBE = fwd_sel(Rs2E);
    end
  end

  assign lw_stall = resultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // Stall/flush mux; a multi-cycle stall freezes F/D/E and masks everything else
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (reset) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else if (mc_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else begin
      if (lw_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      if (PCSrcE != '0) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // Stall-cycle counter saturates rather than wrapping
  always_comb begin
    stall_count_d = stall_count_q;
    if (stallF && (stall_count_q != '1)) stall_count_d = stall_count_q + PERF_W'(1);
  end

  // Perf counter register
  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: table of combinational vectors plus
// hand-written multi-cycle, reset and counter-saturation sequences.
module tb_hazard_ctrl_mc;

  localparam int PERF_W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       regWriteM, regWriteW, luiM, resultSrcE0;
  logic [1:0] PCSrcE;
  logic       mcStartE;
  logic [3:0] mcLatE;
  logic       stallF, stallD, stallE, flushD, flushE, flushM;
  logic [1:0] forwardAE, forwardBE;
  logic       mcBusy;
  logic [PERF_W-1:0] stallCount;
  logic [5:0] ctl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(5), .LAT_W(4), .PERF_W(PERF_W), .PCSRC_W(2)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .luiM(luiM),
    .resultSrcE0(resultSrcE0), .PCSrcE(PCSrcE),
    .mcStartE(mcStartE), .mcLatE(mcLatE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mcBusy(mcBusy), .stallCount(stallCount)
  );

  // {stallF, stallD, stallE, flushD, flushE, flushM}
  assign ctl = {stallF, stallD, stallE, flushD, flushE, flushM};

  typedef struct {
    int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    int rwm, rww, lui, ld, pc;
    int fa, fb, ctl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    regWriteM = 0; regWriteW = 0; luiM = 0; resultSrcE0 = 0; PCSrcE = '0;
    mcStartE = 0; mcLatE = '0;
  endtask

  task automatic drive(input vec_t v);
    Rs1D = v.rs1d[4:0]; Rs2D = v.rs2d[4:0]; Rs1E = v.rs1e[4:0]; Rs2E = v.rs2e[4:0];
    RdE = v.rde[4:0]; RdM = v.rdm[4:0]; RdW = v.rdw[4:0];
    regWriteM = v.rwm[0]; regWriteW = v.rww[0]; luiM = v.lui[0];
    resultSrcE0 = v.ld[0]; PCSrcE = v.pc[1:0];
  endtask

  // Start of a new cycle: inputs driven after negedge, outputs sampled #1 later
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    //            rs1d rs2d rs1e rs2e rde rdm rdw rwm rww lui ld pc  fa fb ctl
    vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 2, 0, 'b000000};
    vecs[1]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 1, 0, 0, 3, 0, 'b000000};
    vecs[2]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 0, 1, 0, 'b000000};
    vecs[3]  = '{0, 0, 0, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 0, 'b000000};
    vecs[4]  = '{0, 0, 3, 9, 0, 3, 9, 1, 1, 0, 0, 0, 2, 1, 'b000000};
    vecs[5]  = '{1, 7, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'b110010};
    vecs[6]  = '{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'b000000};
    vecs[7]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b000000};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'b000110};
    vecs[9]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 'b110110};
    vecs[10] = '{7, 3, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'b110010};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 'b000000};
    vecs[12] = '{0, 0, 4, 6, 0, 4, 6, 0, 0, 0, 0, 0, 0, 0, 'b000000};

    // Reset: flushes high, forwarding forced to 00 even with a matching M producer
    clr();
    reset = 1;
    Rs1E = 5'd5; RdM = 5'd5; regWriteM = 1;
    cyc(); #1;
    chk("rst_ctl", 32'(ctl), 32'b000111);
    chk("rst_fa", 32'(forwardAE), 0);
    cyc(); #1;
    chk("rst_busy", 32'(mcBusy), 0);
    cyc();
    reset = 0; clr(); #1;
    chk("post_rst_ctl", 32'(ctl), 0);
    chk("post_rst_cnt", 32'(stallCount), 0);

    // Combinational vector table, timer idle
    for (int i = 0; i < 13; i++) begin
      cyc();
      drive(vecs[i]); #1;
      chk($sformatf("vec%0d_fa", i), 32'(forwardAE), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_fb", i), 32'(forwardBE), 32'(vecs[i].fb));
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
    end

    // mcLatE=4: stall cycles 1-3, released in cycle 4, busy cycles 2-4
    cyc(); clr(); mcStartE = 1; mcLatE = 4'd4;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) cyc();
      #1;
      chk($sformatf("mc4_c%0d_ctl", c), 32'(ctl), (c < 4) ? 32'b111001 : 32'b000000);
      chk($sformatf("mc4_c%0d_busy", c), 32'(mcBusy), (c > 1) ? 1 : 0);
    end
    cyc(); mcStartE = 0; #1;
    chk("mc4_after_busy", 32'(mcBusy), 0);

    // mcLatE=1 and 0: never stall
    cyc(); mcStartE = 1; mcLatE = 4'd1; #1;
    chk("mc1_ctl", 32'(ctl), 0);
    cyc(); mcLatE = 4'd0; #1;
    chk("mc1_busy", 32'(mcBusy), 0);
    chk("mc0_ctl", 32'(ctl), 0);

    // mc op masks branch and load-use; they reappear once the stall releases
    cyc(); clr(); mcStartE = 1; mcLatE = 4'd4;
    PCSrcE = 2'b01; resultSrcE0 = 1; RdE = 5'd7; Rs2D = 5'd7;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) cyc();
      #1;
      chk($sformatf("mask_c%0d_ctl", c), 32'(ctl), (c < 4) ? 32'b111001 : 32'b110110);
    end

    // Back-to-back: L=2 then L=3 with no idle gap
    cyc(); clr(); mcStartE = 1; mcLatE = 4'd2; #1;
    chk("b2b_a1", 32'(ctl), 32'b111001);
    cyc(); #1;
    chk("b2b_a2", 32'(ctl), 0);
    chk("b2b_a2_busy", 32'(mcBusy), 1);
    cyc(); mcLatE = 4'd3; #1;
    chk("b2b_b1", 32'(ctl), 32'b111001);
    chk("b2b_b1_busy", 32'(mcBusy), 0);
    cyc(); #1;
    chk("b2b_b2", 32'(ctl), 32'b111001);
    cyc(); #1;
    chk("b2b_b3", 32'(ctl), 0);
    cyc(); mcStartE = 0; #1;
    chk("b2b_idle", 32'(mcBusy), 0);

    // Reset in second BUSY cycle of mcLatE=6
    cyc(); mcStartE = 1; mcLatE = 4'd6; #1;
    chk("rmc_c1", 32'(ctl), 32'b111001);
    cyc(); reset = 1; #1;
    chk("rmc_rst_ctl", 32'(ctl), 32'b000111);
    chk("rmc_rst_busy", 32'(mcBusy), 1);
    cyc(); reset = 0; mcStartE = 0; #1;
    chk("rmc_busy", 32'(mcBusy), 0);
    chk("rmc_ctl", 32'(ctl), 0);
    chk("rmc_cnt", 32'(stallCount), 0);
    cyc(); #1;
    chk("rmc_busy2", 32'(mcBusy), 0);
    chk("rmc_ctl2", 32'(ctl), 0);

    // Saturation: L=15 gives 14 stall cycles, then L=4 adds 3 more -> 15
    cyc(); reset = 1;
    cyc(); reset = 0; mcStartE = 1; mcLatE = 4'd15;
    for (int c = 2; c <= 15; c++) cyc();
    #1;
    chk("sat_cnt14", 32'(stallCount), 14);
    cyc(); mcLatE = 4'd4;
    for (int c = 2; c <= 4; c++) cyc();
    #1;
    chk("sat_cnt15", 32'(stallCount), 15);
    cyc(); mcStartE = 0; #1;
    chk("sat_hold", 32'(stallCount), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised hazard controller for the 5-stage RISC-V pipeline, successor to the single-cycle hazard unit. Adds full MEM/WB forwarding with LUI bypass, a multi-cycle execute stall (iterative mul/div) driven by a latency counter, an M-stage bubble during that stall, and a saturating stall-cycle performance counter. Sits beside the pipeline registers and drives their stall/flush enables and the E-stage forwarding muxes.

## Interface
- REG_AW, 5, register-address width
- LAT_W, 4, width of multi-cycle latency field
- PERF_W, 16, width of stall counter
- PCSRC_W, 2, width of PCSrcE
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- Rs1D, Rs2D  in  REG_AW  D-stage source registers
- Rs1E, Rs2E, RdE  in  REG_AW  E-stage sources and destination
- RdM, RdW  in  REG_AW  M- and W-stage destinations
- regWriteM, regWriteW  in  1  M/W write enables
- luiM  in  1  M-stage instruction is LUI
- resultSrcE0  in  1  E-stage instruction is a load
- PCSrcE  in  PCSRC_W  nonzero = taken branch/jump in E
- mcStartE  in  1  E-stage instruction is multi-cycle
- mcLatE  in  LAT_W  total E-stage cycles for that instruction
- stallF, stallD, stallE  out  1  hold pipeline registers
- flushD, flushE, flushM  out  1  bubble into D/E/M registers
- forwardAE, forwardBE  out  2  operand mux selects
- mcBusy  out  1  multi-cycle timer in BUSY
- stallCount  out  PERF_W  cycles with stallF=1, saturating

## Operation
- Forwarding, per operand (A uses Rs1E, B uses Rs2E), priority order: Rs==0 -> 00; Rs==RdM && regWriteM -> luiM ? 11 : 10; Rs==RdW && regWriteW -> 01; else 00. Combinational.
- Load-use: lwStall = resultSrcE0 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
- Multi-cycle FSM, states IDLE, BUSY; counter cnt (LAT_W).
  - IDLE, mcStartE && mcLatE>=2: mcStall=1; next BUSY, cnt<=mcLatE-2.
  - IDLE, mcLatE<=1 or !mcStartE: no stall, stay IDLE.
  - BUSY, cnt!=0: mcStall=1, cnt<=cnt-1.
  - BUSY, cnt==0: mcStall=0, next IDLE; mcStartE ignored in BUSY (same instruction).
- Outputs (reset low):
  - mcStall: stallF=stallD=stallE=1, flushM=1, flushD=flushE=0; lwStall and PCSrcE masked.
  - else lwStall: stallF=stallD=1, flushE=1.
  - PCSrcE!=0 (no mcStall): flushD=flushE=1. lwStall and branch together: flushD=flushE=1, stallF=stallD=1.
- mcBusy = (state==BUSY).
- stallCount increments when stallF=1, holds at all-ones.

## Timing
- Forward selects, stall/flush: combinational from inputs and current state, zero latency.
- Multi-cycle instruction with latency L>=2 occupies E exactly L cycles; stalls asserted first L-1 cycles, released in cycle L.
- Back-to-back multi-cycle ops: second starts in the IDLE cycle after the first leaves E; no idle gap.
- Reset (any state, incl. mid-BUSY): next edge state=IDLE, cnt=0, stallCount=0. While reset high: stallF/D/E=0, flushD/E/M=1, forward selects 00, mcBusy reflects registered state until the edge.
- After reset release: all outputs 0 / per inputs, mcBusy=0, stallCount=0.

## Structure
- Package hazard_pkg: forward encodings FWD_NONE=00, FWD_WB=01, FWD_MEM=10, FWD_LUI=11; FSM state enum.
- Sub-module mc_stall_timer: FSM + cnt, outputs mcStall, mcBusy. Forwarding, load-use, flush mux and perf counter in top.

## Test plan
- Rs1E=5, RdM=5, regWriteM=1, luiM=0, RdW=5, regWriteW=1 -> forwardAE=10; with luiM=1 -> 11; regWriteM=0 -> 01; Rs1E=0 -> 00.
- resultSrcE0=1, RdE=7, Rs2D=7 -> stallF=stallD=flushE=1 one cycle; RdE=0 -> no stall.
- mcStartE=1, mcLatE=4 -> stallF/D/E and flushM high 3 cycles, low on 4th, mcBusy high cycles 2-4; mcLatE=1 -> no stall.
- Multi-cycle op with PCSrcE=01 and lwStall condition in same cycle -> only mc stalls; flushD=flushE=0.
- Reset asserted in 2nd BUSY cycle of mcLatE=6 -> next cycle IDLE, mcBusy=0, stallCount=0, no residual stall.
- Hold stallF via repeated mc ops with PERF_W=4 -> stallCount saturates at 15.
